// File: rtl/uncached_arbiter_pkg.sv
// Shared bus types, size/length encodings and FSM states for the uncached arbiter.
package uncached_arbiter_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        BUS_I,
        BUS_D,
        RESP_I,
        RESP_D
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

endpackage

// File: rtl/uncached_arbiter_rr_arb2.sv
// Two-way grant selection: round-robin on contention, optional fixed D priority.
module uncached_arbiter_rr_arb2
    import uncached_arbiter_pkg::*;
#(
    parameter bit FIXED_D = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic grant_i,
    output logic grant_d
);

    port_t last_grant;

    // Pick the winner; on contention favour D unless D won last time.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (en) begin
            if (req_i && req_d) begin
                if (FIXED_D || last_grant == PORT_I) grant_d = 1'b1;
                else                                 grant_i = 1'b1;
            end else begin
                grant_i = req_i;
                grant_d = req_d;
            end
        end
    end

    // Remember the most recent winner.
    always_ff @(posedge clk) begin
        if (reset)        last_grant <= PORT_I;
        else if (grant_d) last_grant <= PORT_D;
        else if (grant_i) last_grant <= PORT_I;
    end

endmodule

// File: rtl/uncached_arbiter.sv
// Funnels uncached instruction/data requests onto a single-beat memory bus, one at a time.
module uncached_arbiter
    import uncached_arbiter_pkg::*;
#(
    parameter int DATA_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    input  logic       i_uncached,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    input  logic       d_uncached,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    state_t      state, state_n;
    cbus_req_t   req_q, req_n;
    logic [31:0] data_q, data_n;
    logic        elig_i, elig_d, arb_en, grant_i, grant_d;

    assign elig_i = ireq.valid & i_uncached;
    assign elig_d = dreq.valid & d_uncached;
    // Arbitration is masked during reset so a held request never sees addr_ok.
    assign arb_en = (state == IDLE) & ~reset;

    uncached_arbiter_rr_arb2 #(
        .FIXED_D (DATA_PRIO != 0)
    ) u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .req_i   (elig_i),
        .req_d   (elig_d),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // State, latched request and captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            req_q  <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            req_q  <= req_n;
            data_q <= data_n;
        end
    end

    // Next state and all port outputs.
    always_comb begin
        state_n = state;
        req_n   = req_q;
        data_n  = data_q;
        iresp   = '0;
        dresp   = '0;
        creq    = '0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    dresp.addr_ok = 1'b1;
                    req_n = '{valid: 1'b1, is_write: |dreq.strobe, size: dreq.size,
                              addr: dreq.addr, strobe: dreq.strobe, data: dreq.data,
                              len: MLEN1};
                    state_n = BUS_D;
                end else if (grant_i) begin
                    iresp.addr_ok = 1'b1;
                    req_n = '{valid: 1'b1, is_write: 1'b0, size: MSIZE4,
                              addr: ireq.addr, strobe: 4'b0000, data: '0,
                              len: MLEN1};
                    state_n = BUS_I;
                end
            end
            BUS_I, BUS_D: begin
                creq = req_q;
                if (cresp.ready && cresp.last) begin
                    data_n  = cresp.data;
                    state_n = (state == BUS_I) ? RESP_I : RESP_D;
                end
            end
            RESP_I: begin
                if (!reset) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = data_q;
                end
                state_n = IDLE;
            end
            RESP_D: begin
                if (!reset) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = data_q;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uncached_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances driven in lockstep.
module tb_uncached_arbiter;
    import uncached_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    logic       i_unc;
    dbus_req_t  dreq;
    logic       d_unc;
    cbus_resp_t cresp;
    ibus_resp_t iresp_w [2];
    dbus_resp_t dresp_w [2];
    cbus_req_t  creq_w  [2];

    always #5 clk = ~clk;

    uncached_arbiter #(.DATA_PRIO(0)) u_rr (
        .clk(clk), .reset(reset), .ireq(ireq), .i_uncached(i_unc), .iresp(iresp_w[0]),
        .dreq(dreq), .d_uncached(d_unc), .dresp(dresp_w[0]), .creq(creq_w[0]), .cresp(cresp));

    uncached_arbiter #(.DATA_PRIO(1)) u_fp (
        .clk(clk), .reset(reset), .ireq(ireq), .i_uncached(i_unc), .iresp(iresp_w[1]),
        .dreq(dreq), .d_uncached(d_unc), .dresp(dresp_w[1]), .creq(creq_w[1]), .cresp(cresp));

    typedef struct {
        port_t       port;
        cbus_req_t   creq;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb [2][$];
    port_t       last_m [2];
    bit          dprio [2];
    logic [1:0]  exp_acc [2];
    logic        exp_bus, exp_dok;
    bit          mon_en;
    int unsigned n_checks, n_pass;

    ibus_resp_t  m_ei;
    dbus_resp_t  m_ed;
    cbus_req_t   m_ec;
    bit          m_have;

    task automatic check(input string name, input int k, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t got %h expected %h", name, k, $time, got, exp);
    endtask

    function automatic cbus_req_t mk_creq(input port_t p, input ibus_req_t iq, input dbus_req_t dq);
        cbus_req_t c;
        c = '0;
        c.valid = 1'b1;
        c.len   = MLEN1;
        if (p == PORT_D) begin
            c.is_write = (dq.strobe != 4'b0);
            c.size     = dq.size;
            c.addr     = dq.addr;
            c.strobe   = dq.strobe;
            c.data     = dq.data;
        end else begin
            c.size = MSIZE4;
            c.addr = iq.addr;
        end
        return c;
    endfunction

    task automatic rand_junk();
        ireq.valid  = 1'($urandom);
        ireq.addr   = $urandom;
        i_unc       = 1'($urandom);
        dreq.valid  = 1'($urandom);
        dreq.addr   = $urandom;
        dreq.size   = msize_t'(3'($urandom_range(0, 2)));
        dreq.strobe = 4'($urandom);
        dreq.data   = $urandom;
        d_unc       = 1'($urandom);
    endtask

    task automatic clear_exp();
        exp_acc[0] = 2'b00;
        exp_acc[1] = 2'b00;
    endtask

    // IDLE cycle: present requests and predict each instance's grant.
    task automatic present(input ibus_req_t iq, input logic iu, input dbus_req_t dq,
                           input logic du, input logic [31:0] rdata, output bit any);
        bit    ei, ed;
        port_t win;
        exp_t  e;
        @(posedge clk); #1;
        ireq = iq; i_unc = iu; dreq = dq; d_unc = du;
        cresp = '0; exp_bus = 1'b0; exp_dok = 1'b0;
        clear_exp();
        ei  = iq.valid && iu;
        ed  = dq.valid && du;
        any = ei || ed;
        if (any) begin
            for (int k = 0; k < 2; k++) begin
                if (ei && ed) win = (dprio[k] || last_m[k] == PORT_I) ? PORT_D : PORT_I;
                else          win = ed ? PORT_D : PORT_I;
                last_m[k]  = win;
                exp_acc[k] = (win == PORT_D) ? 2'b10 : 2'b01;
                e.port  = win;
                e.creq  = mk_creq(win, iq, dq);
                e.rdata = rdata;
                sb[k].push_back(e);
            end
        end
    endtask

    task automatic txn(input ibus_req_t iq, input logic iu, input dbus_req_t dq,
                       input logic du, input int unsigned waits, input logic [31:0] rdata);
        bit any;
        present(iq, iu, dq, du, rdata, any);
        if (!any) return;
        for (int unsigned w = 0; w < waits; w++) begin
            @(posedge clk); #1;
            rand_junk(); clear_exp(); exp_bus = 1'b1;
            cresp.ready = 1'($urandom);
            cresp.last  = !cresp.ready && 1'($urandom);
            cresp.data  = $urandom;
        end
        @(posedge clk); #1;
        rand_junk(); clear_exp(); exp_bus = 1'b1;
        cresp.ready = 1'b1; cresp.last = 1'b1; cresp.data = rdata;
        @(posedge clk); #1;
        rand_junk(); exp_bus = 1'b0; exp_dok = 1'b1;
        cresp.ready = 1'($urandom); cresp.last = 1'($urandom); cresp.data = $urandom;
    endtask

    task automatic after_reset();
        sb[0].delete(); sb[1].delete();
        last_m[0] = PORT_I; last_m[1] = PORT_I;
    endtask

    // Monitor: every cycle compare both instances against the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) begin
                    m_ei = '0; m_ed = '0; m_ec = '0;
                    m_ei.addr_ok = exp_acc[k][0];
                    m_ed.addr_ok = exp_acc[k][1];
                    m_have = (sb[k].size() != 0);
                    if ((exp_bus || exp_dok) && !m_have)
                        check("sb_underflow", k, 128'(sb[k].size()), 128'(1));
                    if (m_have && exp_bus) m_ec = sb[k][0].creq;
                    if (m_have && exp_dok) begin
                        if (sb[k][0].port == PORT_I) begin
                            m_ei.data_ok = 1'b1;
                            m_ei.data    = sb[k][0].rdata;
                        end else begin
                            m_ed.data_ok = 1'b1;
                            m_ed.data    = sb[k][0].creq.is_write ? dresp_w[k].data : sb[k][0].rdata;
                        end
                    end
                    check("iresp", k, 128'(iresp_w[k]), 128'(m_ei));
                    check("dresp", k, 128'(dresp_w[k]), 128'(m_ed));
                    check("creq",  k, 128'(creq_w[k]),  128'(m_ec));
                    if (m_have && exp_dok) void'(sb[k].pop_front());
                end
            end
        end
    end

    initial begin
        ibus_req_t iq, i0;
        dbus_req_t dq, d0;
        bit        any;

        dprio[0] = 1'b0; dprio[1] = 1'b1;
        after_reset();
        i0 = '0; d0 = '0;
        reset = 1'b1; ireq = '0; dreq = '0; i_unc = 1'b0; d_unc = 1'b0; cresp = '0;
        exp_bus = 1'b0; exp_dok = 1'b0; clear_exp();
        mon_en = 1'b0;
        n_checks = 0; n_pass = 0;

        @(posedge clk); #1; mon_en = 1'b1;
        @(posedge clk); #1; reset = 1'b0;

        // Contention from reset: RR gives D,I,D; fixed priority gives D,D,D.
        for (int n = 0; n < 3; n++) begin
            iq.valid = 1'b1; iq.addr = 32'h1fc0_0000 + 32'(n * 4);
            dq.valid = 1'b1; dq.addr = 32'h1faf_0100 + 32'(n * 4);
            dq.size = MSIZE4; dq.strobe = 4'h0; dq.data = '0;
            txn(iq, 1'b1, dq, 1'b1, 0, 32'h1000_0000 + 32'(n));
        end

        // Single I read.
        iq.valid = 1'b1; iq.addr = 32'h1fc0_0000;
        txn(iq, 1'b1, d0, 1'b0, 0, 32'h3c08_0000);

        // D write.
        dq.valid = 1'b1; dq.addr = 32'h1faf_0000; dq.size = MSIZE4;
        dq.strobe = 4'hf; dq.data = 32'hdead_beef;
        txn(i0, 1'b0, dq, 1'b1, 0, 32'h0);

        // Long wait with the D request changing underneath.
        dq.valid = 1'b1; dq.addr = 32'h1faf_0040; dq.size = MSIZE2;
        dq.strobe = 4'h0; dq.data = '0;
        txn(i0, 1'b0, dq, 1'b1, 5, 32'hcafe_f00d);

        // Cached D request is ignored.
        dq.valid = 1'b1; dq.addr = 32'h8000_0000; dq.strobe = 4'h3;
        txn(i0, 1'b0, dq, 1'b0, 0, 32'h0);
        txn(i0, 1'b0, d0, 1'b0, 0, 32'h0);

        // Reset while in BUS_D abandons the transaction.
        dq.valid = 1'b1; dq.addr = 32'h1faf_0080; dq.size = MSIZE4;
        dq.strobe = 4'h0; dq.data = '0;
        present(i0, 1'b0, dq, 1'b1, 32'h5555_aaaa, any);
        @(posedge clk); #1;
        reset = 1'b1; clear_exp(); exp_bus = 1'b1;
        cresp.ready = 1'b1; cresp.last = 1'b1; cresp.data = 32'h5555_aaaa;
        @(posedge clk); #1;
        reset = 1'b0; exp_bus = 1'b0; cresp = '0;
        ireq = '0; dreq = '0; i_unc = 1'b0; d_unc = 1'b0;
        after_reset();
        iq.valid = 1'b1; iq.addr = 32'h1fc0_0100;
        txn(iq, 1'b1, d0, 1'b0, 1, 32'h2402_0001);

        // Reset held with eligible requests on both ports.
        @(posedge clk); #1;
        reset = 1'b1; clear_exp(); exp_bus = 1'b0; exp_dok = 1'b0; cresp = '0;
        for (int n = 0; n < 3; n++) begin
            ireq.valid = 1'b1; i_unc = 1'b1; dreq.valid = 1'b1; d_unc = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b0; ireq = '0; dreq = '0;
        after_reset();

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            iq.valid = 1'($urandom); iq.addr = $urandom;
            dq.valid = 1'($urandom); dq.addr = $urandom;
            dq.size = msize_t'(3'($urandom_range(0, 2)));
            dq.strobe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            dq.data = $urandom;
            txn(iq, ($urandom_range(0, 3) != 0), dq, ($urandom_range(0, 3) != 0),
                $urandom_range(0, 4), $urandom);
        end

        @(posedge clk); #1;
        ireq = '0; dreq = '0; cresp = '0; clear_exp(); exp_bus = 1'b0; exp_dok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check("sb_drain", k, 128'(sb[k].size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
